// File: rtl/gate_vector_checker.sv
// Exhaustive stimulus/response checker for a 2-input gate: it sweeps {in1,in2} through 00..11,
// compares the DUT output with the TRUTH table after a settle window, and reports a verdict.
module gate_vector_checker #(
    parameter logic [3:0] TRUTH  = 4'b1000,
    parameter int         SETTLE = 4,
    parameter int         PASSES = 1,
    parameter int         ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_out,
    output logic             in1,
    output logic             in2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_fail_vec
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] APPLY = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

    logic [1:0]       state;
    logic [1:0]       vec;
    logic [SW-1:0]    settle_cnt;
    logic [PW-1:0]    pass_cnt;
    logic             fail_flag;
    logic             mismatch;
    logic [ERR_W-1:0] err_next;

    assign busy = (state == APPLY) || (state == CHECK);
    assign done = (state == DONE);
    // The vector is only presented while a run is active; otherwise the DUT sees 00.
    assign in1  = busy & vec[1];
    assign in2  = busy & vec[0];

    assign mismatch = (state == CHECK) && (dut_out != TRUTH[vec]);
    assign err_next = (mismatch && (err_count != {ERR_W{1'b1}})) ?
                      err_count + ERR_W'(1) : err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            vec            <= 2'b00;
            settle_cnt     <= '0;
            pass_cnt       <= '0;
            fail_flag      <= 1'b0;
            err_count      <= '0;
            pass           <= 1'b0;
            first_fail_vec <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= APPLY;
                        vec            <= 2'b00;
                        settle_cnt     <= '0;
                        pass_cnt       <= '0;
                        fail_flag      <= 1'b0;
                        err_count      <= '0;
                        pass           <= 1'b0;
                        first_fail_vec <= 2'b00;
                    end
                end
                APPLY: begin
                    if (settle_cnt == SW'(SETTLE - 1)) begin
                        settle_cnt <= '0;
                        state      <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                CHECK: begin
                    err_count <= err_next;
                    if (mismatch && !fail_flag) begin
                        first_fail_vec <= vec;
                        fail_flag      <= 1'b1;
                    end
                    if (vec != 2'b11) begin
                        vec   <= vec + 2'b01;
                        state <= APPLY;
                    end else if (pass_cnt != PW'(PASSES - 1)) begin
                        vec      <= 2'b00;
                        pass_cnt <= pass_cnt + PW'(1);
                        state    <= APPLY;
                    end else begin
                        // Verdict includes a mismatch seen on this very cycle.
                        pass  <= (err_next == '0);
                        state <= DONE;
                    end
                end
                default: begin
                    vec   <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: a table of gate models run through a default
// instance, plus hand sequences for multi-pass, saturation, reset and held-start cases.
module tb_gate_vector_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic       dut_out_a;
    logic       dut_out_b = 1'b1, dut_out_c = 1'b1;
    int         mode = 0;

    logic       in1_a, in2_a, busy_a, done_a, pass_a;
    logic [7:0] err_a;
    logic [1:0] ffv_a;
    logic       in1_b, in2_b, busy_b, done_b, pass_b;
    logic [7:0] err_b;
    logic [1:0] ffv_b;
    logic       in1_c, in2_c, busy_c, done_c, pass_c;
    logic [1:0] err_c;
    logic [1:0] ffv_c;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Gate models presented to instance A.
    always_comb begin
        dut_out_a = 1'b0;
        case (mode)
            0: dut_out_a = in1_a & in2_a;
            1: dut_out_a = 1'b0;
            2: dut_out_a = 1'b1;
            3: dut_out_a = in1_a ^ in2_a;
            4: dut_out_a = in1_a | in2_a;
            5: dut_out_a = ~(in1_a & in2_a);
            default: dut_out_a = 1'b0;
        endcase
    end

    gate_vector_checker u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .dut_out(dut_out_a),
        .in1(in1_a), .in2(in2_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_fail_vec(ffv_a)
    );

    gate_vector_checker #(.PASSES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(dut_out_b),
        .in1(in1_b), .in2(in2_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_fail_vec(ffv_b)
    );

    gate_vector_checker #(.PASSES(4), .ERR_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .dut_out(dut_out_c),
        .in1(in1_c), .in2(in2_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .first_fail_vec(ffv_c)
    );

    typedef struct {
        int         mode;
        logic       repulse;
        int         exp_err;
        logic [1:0] exp_ffv;
        logic       exp_pass;
    } run_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Start a run on A and follow it cycle by cycle; n counts edges after the start edge.
    task automatic run_a(input run_t r);
        int done_at;
        int seq_err;
        mode = r.mode;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        done_at = -1;
        seq_err = 0;
        for (int n = 0; n <= 40; n++) begin
            if (n > 0) @(negedge clk);
            start_a = (r.repulse && n == 6);
            if (done_a) begin
                done_at = n;
                break;
            end
            if (n < 20 && (busy_a !== 1'b1 || {in1_a, in2_a} !== 2'(n / 5))) seq_err++;
        end
        check("latency", 32'(done_at), 32'd20);
        check("vector_seq", 32'(seq_err), 32'd0);
        check("err_count", 32'(err_a), 32'(r.exp_err));
        check("first_fail_vec", 32'(ffv_a), 32'(r.exp_ffv));
        check("pass", 32'(pass_a), 32'(r.exp_pass));
        check("idle_in_done", 32'({in1_a, in2_a, busy_a}), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(done_a), 32'd0);
        check("pass_held", 32'(pass_a), 32'(r.exp_pass));
    endtask

    // Wait for done on instance B (which=1) or C (which=2) after its start pulse.
    task automatic wait_bc(input int which, output int edges);
        edges = -1;
        for (int n = 0; n <= 200; n++) begin
            if (n > 0) @(negedge clk);
            if ((which == 1) ? done_b : done_c) begin
                edges = n;
                break;
            end
        end
    endtask

    run_t runs[7];

    initial begin
        int edges;
        int done_seen;
        runs[0] = '{0, 1'b0, 0, 2'b00, 1'b1};  // AND
        runs[1] = '{1, 1'b0, 1, 2'b11, 1'b0};  // stuck 0
        runs[2] = '{2, 1'b0, 3, 2'b00, 1'b0};  // stuck 1
        runs[3] = '{3, 1'b0, 3, 2'b01, 1'b0};  // XOR
        runs[4] = '{4, 1'b0, 2, 2'b01, 1'b0};  // OR
        runs[5] = '{5, 1'b0, 4, 2'b00, 1'b0};  // NAND
        runs[6] = '{0, 1'b1, 0, 2'b00, 1'b1};  // AND with start re-pulsed mid-run

        #3;
        check("reset_a", 32'({in1_a, in2_a, busy_a, done_a, pass_a, err_a, ffv_a}), 32'd0);
        check("reset_b", 32'({in1_b, in2_b, busy_b, done_b, pass_b, err_b, ffv_b}), 32'd0);
        check("reset_c", 32'({in1_c, in2_c, busy_c, done_c, pass_c, err_c, ffv_c}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_a(runs[i]);

        // Two passes with the output stuck high.
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_bc(1, edges);
        check("b_latency", 32'(edges), 32'd40);
        check("b_err_count", 32'(err_b), 32'd6);
        check("b_first_fail", 32'(ffv_b), 32'd0);
        check("b_pass", 32'(pass_b), 32'd0);

        // Twelve mismatches into a 2-bit counter.
        @(negedge clk);
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        wait_bc(2, edges);
        check("c_latency", 32'(edges), 32'd80);
        check("c_err_sat", 32'(err_c), 32'd3);
        check("c_pass", 32'(pass_c), 32'd0);

        // Reset while vector 10 is applied.
        mode = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (12) @(negedge clk);
        check("pre_reset_vec", 32'({in1_a, in2_a}), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 32'({in1_a, in2_a, busy_a, done_a, pass_a, err_a, ffv_a}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_a) done_seen++;
        end
        check("no_done_after_reset", 32'(done_seen), 32'd0);
        run_a(runs[0]);

        // Start held high: next run starts the cycle after DONE returns to IDLE.
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        for (int n = 0; n <= 22; n++) begin
            if (n > 0) @(negedge clk);
            if (n == 20) check("held_done", 32'(done_a), 32'd1);
            if (n == 21) check("held_idle", 32'(busy_a), 32'd0);
            if (n == 22) check("held_restart", 32'(busy_a), 32'd1);
        end
        start_a = 1'b0;
        edges = -1;
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            if (done_a) begin
                edges = n;
                break;
            end
        end
        check("held_second_done", 32'(edges >= 0), 32'd1);
        check("held_second_pass", 32'(pass_a), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
